// File: rtl/param_sync_fifo_pkg.sv
// Shared sizing helpers and default constants for the parametrised synchronous FIFO.
package param_sync_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the occupancy can represent the full value DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// DEPTH x DATA_W storage for param_sync_fifo: synchronous write, asynchronous read.
module fifo_ram
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, sticky error flags and flush.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_rd,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_afull,
  output logic                     o_aempty,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] ram_rdata;

  // Request/accept: i_wr and i_rd are requests sampled every edge. A read is
  // accepted whenever the FIFO holds data; a write is accepted when there is
  // room or when a read in the same edge frees a slot. Rejected requests set
  // the sticky error flags and leave pointers and data untouched.
  assign rd_ok = i_rd & ~o_empty;
  assign wr_ok = i_wr & (~o_full | rd_ok);

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)      count_nxt = count + 1'b1;
    else if (rd_ok && !wr_ok) count_nxt = count - 1'b1;
  end

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PW)) u_ram (
    .clk   (i_clk),
    .we    (wr_ok & ~i_clr),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      // Status flags track the post-edge count so they move together with o_count.
      o_full      <= (count_nxt == CW'(DEPTH));
      o_empty     <= (count_nxt == '0);
      o_afull     <= (count_nxt >= CW'(AF_LEVEL));
      o_aempty    <= (count_nxt <= CW'(AE_LEVEL));
      o_overflow  <= o_overflow | (i_wr & o_full & ~i_rd);
      o_underflow <= o_underflow | (i_rd & o_empty);
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head entry is always presented; meaningless while empty.
  assign o_data = ram_rdata;
`else
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)              data_q <= '0;
    else if (rd_ok && !i_clr) data_q <= ram_rdata;
  end

  assign o_data = data_q;
`endif

  assign o_count = count;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DEPTH=8, AF=6, AE=2).
module tb_param_sync_fifo;
  import param_sync_fifo_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  // Clock / reset and DUT signals
  logic                  clk = 1'b0;
  logic                  rst_n, clr, wr, rd;
  logic [W-1:0]          din, dout;
  logic                  full, empty, afull, aempty, ovf, unf;
  logic [cnt_w(D)-1:0]   count;

  int                    n_tests = 0;
  int                    n_fail  = 0;
  logic [W-1:0]          exp_q[$];
  logic [W-1:0]          last_pop;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_clr       (clr),
    .i_wr        (wr),
    .i_data      (din),
    .i_rd        (rd),
    .o_data      (dout),
    .o_full      (full),
    .o_empty     (empty),
    .o_afull     (afull),
    .o_aempty    (aempty),
    .o_count     (count),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Data check against the expected queue: head word in FWFT, last popped word otherwise.
  task automatic check_data(input string tag);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    if (exp_q.size() > 0) check(tag, dout, exp_q[0]);
`else
    check(tag, dout, last_pop);
`endif
  endtask

  // Driver: present one cycle of requests, update the scoreboard at the edge, sample #1 later.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    bit rdok, wrok;
    wr = w; din = d; rd = r; clr = c;
    @(posedge clk);
    if (c) begin
      exp_q.delete();
    end else begin
      rdok = r && (exp_q.size() > 0);
      wrok = w && ((exp_q.size() < D) || rdok);
      if (rdok) last_pop = exp_q.pop_front();
      if (wrok) exp_q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  logic [W-1:0] drain_exp [8];

  initial begin
    drain_exp = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'hAAAA, 16'hAAAA, 16'hAAAA};
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0; last_pop = '0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_aempty", aempty, 1);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check_data("rst_data");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read
    cycle(1'b1, 16'd3, 1'b0, 1'b0);
    check("t1_count_w", count, 1);
    check("t1_empty_w", empty, 0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_count_r", count, 0);
    check("t1_empty_r", empty, 1);
    check_data("t1_data");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t1_data_hand", dout, 16'd3);
`endif

    // Fill past full
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, W'(k), 1'b0, 1'b0);
      check("t2_count", count, (k > 8) ? 8 : k);
      check("t2_afull", afull, (k >= 6) ? 1 : 0);
      check("t2_full", full, (k >= 8) ? 1 : 0);
      check("t2_ovf", ovf, (k >= 9) ? 1 : 0);
    end

    // Drain past empty
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("t3_count", count, (k >= 8) ? 0 : 8 - k);
      check("t3_empty", empty, (k >= 8) ? 1 : 0);
      check("t3_aempty", aempty, (k >= 6) ? 1 : 0);
      check("t3_unf", unf, (k >= 9) ? 1 : 0);
      check_data("t3_data");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      check("t3_data_hand", dout, (k > 8) ? 8 : k);
`endif
    end
    check("t3_ovf_sticky", ovf, 1);

    // Flush flags, then simultaneous write/read while full
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t4_clr_ovf", ovf, 0);
    check("t4_clr_unf", unf, 0);
    for (int k = 1; k <= 8; k++) cycle(1'b1, W'(k), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'hAAAA, 1'b1, 1'b0);
      check("t4_count", count, 8);
      check("t4_full", full, 1);
      check("t4_ovf", ovf, 0);
      check_data("t4_rw_data");
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_data("t4_drain");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      check("t4_drain_hand", dout, drain_exp[i]);
`endif
    end
    check("t4_empty", empty, 1);

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, W'(100 + i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_data("t5_pair_data");
      check("t5_pair_count", count, 0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'(200 + i), 1'b0, 1'b0);
      check("t5_count", count, i + 1);
      check("t5_aempty", aempty, (i + 1 <= 2) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_data("t5_data");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      check("t5_data_hand", dout, 200 + i);
`endif
    end

    // Flush with pending write while overflow is set
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(300 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'd999, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("t6_pre_count", count, 5);
    check("t6_pre_ovf", ovf, 1);
    cycle(1'b1, 16'h5555, 1'b0, 1'b1);
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_ovf", ovf, 0);
    check("t6_unf", unf, 0);
    check("t6_afull", afull, 0);
    check("t6_aempty", aempty, 1);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t6_data_held", dout, 302);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t6_unf_after", unf, 1);
    check("t6_count_after", count, 0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("t6_dropped", dout, 302);
`endif
    cycle(1'b1, 16'h7777, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_data("t6_resume");

    // Asynchronous reset mid-operation
    cycle(1'b1, 16'd11, 1'b0, 1'b0);
    cycle(1'b1, 16'd22, 1'b0, 1'b0);
    check("t7_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    last_pop = '0;
    check("t7_count", count, 0);
    check("t7_empty", empty, 1);
    check("t7_unf", unf, 0);
    check_data("t7_data");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'd33, 1'b0, 1'b0);
    check("t7_count_w", count, 1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_data("t7_resume");

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Fall-through: head visible without a read
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    check("t8_fwft_head", dout, 16'h1234);
    cycle(1'b1, 16'h5678, 1'b0, 1'b0);
    check("t8_fwft_hold", dout, 16'h1234);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t8_fwft_next", dout, 16'h5678);
`else
    // Registered read: a write alone does not change o_data
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    check("t8_std_hold", dout, 16'd33);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t8_std_read", dout, 16'h1234);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Parametrised successor to the team's fixed 16-bit single-clock FIFO.
- Width, depth and almost-full/almost-empty thresholds are configurable.
- Adds an occupancy count, sticky overflow/underflow error flags and a synchronous flush.
- Used as the operand/result buffer between the host load path and the systolic array, and between array outputs and the writeback stage.

Parameters:
- DATA_W, 16, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, 6, o_afull asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, o_aempty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous flush: empties FIFO, clears error flags
- i_wr  in  1  write request
- i_data  in  DATA_W  write data
- i_rd  in  1  read request
- o_data  out  DATA_W  read data
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_afull  out  1  count >= AF_LEVEL
- o_aempty  out  1  count <= AE_LEVEL
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_overflow  out  1  sticky: write attempted while full and not accepted
- o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (i_rstn low, asynchronous): pointers=0, o_count=0, o_data=0, o_empty=1, o_full=0, o_afull=0, o_aempty=1, o_overflow=0, o_underflow=0. Memory contents are not reset.
- Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Full/empty come from the registered o_count, not from pointer comparison.
- Accept rules, evaluated per edge:
  - wr_ok = i_wr & (~full | rd_ok)
  - rd_ok = i_rd & ~empty
- Full with i_wr and i_rd together: both accepted, count unchanged, no overflow.
- Empty with i_wr and i_rd together: write accepted, read rejected, o_underflow set.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- All status outputs are registered. They reflect the post-edge count in the same cycle o_count updates.
- Read latency, standard mode: o_data updates one edge after an accepted read with the head word, then holds until the next accepted read. A rejected read leaves o_data unchanged.
- Errors: i_wr & full & ~i_rd sets o_overflow. i_rd & empty sets o_underflow. Both stay set until i_clr or reset. Rejected accesses never move pointers or change data.
- i_clr has priority over i_wr/i_rd in the same cycle:
  - pointers, count and error flags return to reset values
  - o_data is held
  - the write presented with i_clr is dropped
- Reset mid-operation: all in-flight accesses are discarded and the FIFO is empty immediately, asynchronously.

Optional Feature:
- Macro: PARAM_SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - o_data always shows the head entry while ~o_empty. A word written into an empty FIFO is visible the edge after the write.
  - i_rd pops the head, and the next entry is visible after that edge.
  - o_data is don't-care while empty. Ports are unchanged.
- Undefined: standard one-cycle registered read as described under Behaviour.

Decomposition:
- Package param_sync_fifo_pkg holds:
  - function ptr_w(depth) = $clog2(depth)
  - function cnt_w(depth) = $clog2(depth)+1
  - default constants DEF_DATA_W=16, DEF_DEPTH=8
- One sub-module, fifo_ram: simple dual-port storage of DEPTH x DATA_W with a synchronous write port and an asynchronous read port. FWFT and the registered read-data path live in the top level.

Test Plan:
- Reset, then write 3, then read: o_count goes 0→1→0. o_data=3 the edge after the read; o_empty=1 at the end.
- With DEPTH=8: write 1..10 back to back. o_full=1 after the 8th write; writes 9 and 10 are dropped and o_overflow=1. o_afull rises when count reaches 6.
- Read 12 times: o_data returns 1..8 in order. o_empty=1 after the 8th read, o_underflow=1, and o_data holds 8 through reads 9-12.
- Fill to 8, then assert i_wr=1, i_rd=1 with data 0xAAAA for 3 cycles: count stays 8, no overflow. Draining afterwards yields 4,5,6,7,8,0xAAAA,0xAAAA,0xAAAA.
- Wrap: alternate 20 write/read pairs, then write 5 and read 5. Data stays in order across pointer wrap. o_aempty=1 at count<=2.
- Flush: with 5 entries and o_overflow set, pulse i_clr together with i_wr. Count=0, o_empty=1, flags cleared, and the written word is not readable afterwards.
- FWFT build: write 0x1234 into an empty FIFO. o_data=0x1234 on the next cycle before any i_rd is issued.
